// File: rtl/ip_ttl_checksum_update.sv
// IPv4 header checksum check and TTL decrement with an RFC 1624 incremental checksum
// update on a 256-bit stream. Word 0 is held until word 1 delivers the last header half-word.
//
// state | meaning
// IDLE  | hold register empty, waiting for word 0
// HOLD  | word 0 held, waiting for word 1 to complete the checksum
// BODY  | streaming, hold register runs one beat behind the input
// DRAIN | last beat held, input stalled until it moves to the output
module ip_ttl_checksum_update #(
   parameter int C_M_AXIS_DATA_WIDTH  = 256,
   parameter int C_S_AXIS_DATA_WIDTH  = 256,
   parameter int C_M_AXIS_TUSER_WIDTH = 128,
   parameter int C_S_AXIS_TUSER_WIDTH = 128,
   parameter int FLAG_POS             = 32
) (
   input  logic                              AXI_ACLK,
   input  logic                              reset,
   input  logic [C_S_AXIS_DATA_WIDTH-1:0]    S_AXIS_TDATA,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  S_AXIS_TSTRB,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   S_AXIS_TUSER,
   input  logic                              S_AXIS_TVALID,
   input  logic                              S_AXIS_TLAST,
   output logic                              S_AXIS_TREADY,
   output logic [C_M_AXIS_DATA_WIDTH-1:0]    M_AXIS_TDATA,
   output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  M_AXIS_TSTRB,
   output logic [C_M_AXIS_TUSER_WIDTH-1:0]   M_AXIS_TUSER,
   output logic                              M_AXIS_TVALID,
   output logic                              M_AXIS_TLAST,
   input  logic                              M_AXIS_TREADY,
   output logic [31:0]                       bad_checksum_count,
   output logic [31:0]                       ttl_expired_count
);

   typedef enum logic [1:0] {IDLE, HOLD, BODY, DRAIN} state_t;

   state_t                              state_q, state_d;
   logic [C_S_AXIS_DATA_WIDTH-1:0]      h_data_q, h_data_d;
   logic [C_S_AXIS_DATA_WIDTH/8-1:0]    h_strb_q, h_strb_d;
   logic [C_S_AXIS_TUSER_WIDTH-1:0]     h_user_q, h_user_d;
   logic                                h_last_q, h_last_d;
   logic [C_M_AXIS_DATA_WIDTH-1:0]      o_data_q, o_data_d;
   logic [C_M_AXIS_DATA_WIDTH/8-1:0]    o_strb_q, o_strb_d;
   logic [C_M_AXIS_TUSER_WIDTH-1:0]     o_user_q, o_user_d;
   logic                                o_valid_q, o_valid_d;
   logic                                o_last_q, o_last_d;
   logic [31:0]                         bad_cnt_q, bad_cnt_d;
   logic [31:0]                         ttl_cnt_q, ttl_cnt_d;

   logic                                slot_free, s_ready, accept;
   logic                                eligible, csum_ok, ttl_gt1, rewrite;
   logic [19:0]                         sum_raw;
   logic [16:0]                         fold1, hc_inc;
   logic [15:0]                         fold2, hc_new;
   logic [C_S_AXIS_DATA_WIDTH-1:0]      proc_data;
   logic [C_S_AXIS_TUSER_WIDTH-1:0]     proc_user, in_user;

   assign slot_free = !o_valid_q | M_AXIS_TREADY;
   assign s_ready   = (state_q == DRAIN) ? 1'b0 : slot_free;
   assign accept    = S_AXIS_TVALID & s_ready;

   // Word 0 sits in H; the tenth header half-word is taken straight off the input bus.
   always_comb begin
      sum_raw = {4'd0, S_AXIS_TDATA[255:240]};
      for (int i = 0; i < 9; i++) begin
         sum_raw = sum_raw + {4'd0, h_data_q[16*i +: 16]};
      end
      fold1    = {1'b0, sum_raw[15:0]} + {13'd0, sum_raw[19:16]};
      fold2    = fold1[15:0] + {15'd0, fold1[16]};
      eligible = (h_data_q[159:144] == 16'h0800) && (h_data_q[143:136] == 8'h45);
      csum_ok  = (fold2 == 16'hFFFF);
      ttl_gt1  = (h_data_q[79:72] > 8'd1);
      rewrite  = eligible & csum_ok & ttl_gt1;
      hc_inc   = {1'b0, h_data_q[63:48]} + 17'h0100;
      hc_new   = hc_inc[15:0] + {15'd0, hc_inc[16]};

      proc_data = h_data_q;
      if (rewrite) begin
         proc_data[79:72] = h_data_q[79:72] - 8'd1;
         proc_data[63:48] = hc_new;
      end
      proc_user = h_user_q;
      proc_user[FLAG_POS +: 3] = eligible ? {csum_ok & ~ttl_gt1, csum_ok, 1'b1} : 3'b000;

      in_user = S_AXIS_TUSER;
      in_user[FLAG_POS +: 3] = 3'b000;
   end

   always_comb begin
      state_d   = state_q;
      h_data_d  = h_data_q;
      h_strb_d  = h_strb_q;
      h_user_d  = h_user_q;
      h_last_d  = h_last_q;
      o_data_d  = o_data_q;
      o_strb_d  = o_strb_q;
      o_user_d  = o_user_q;
      o_last_d  = o_last_q;
      o_valid_d = o_valid_q & ~slot_free;
      bad_cnt_d = bad_cnt_q;
      ttl_cnt_d = ttl_cnt_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               if (S_AXIS_TLAST) begin
                  o_data_d  = S_AXIS_TDATA;
                  o_strb_d  = S_AXIS_TSTRB;
                  o_user_d  = in_user;
                  o_last_d  = 1'b1;
                  o_valid_d = 1'b1;
               end else begin
                  h_data_d = S_AXIS_TDATA;
                  h_strb_d = S_AXIS_TSTRB;
                  h_user_d = S_AXIS_TUSER;
                  h_last_d = 1'b0;
                  state_d  = HOLD;
               end
            end
         end
         HOLD: begin
            if (accept) begin
               o_data_d  = proc_data;
               o_strb_d  = h_strb_q;
               o_user_d  = proc_user;
               o_last_d  = 1'b0;
               o_valid_d = 1'b1;
               h_data_d  = S_AXIS_TDATA;
               h_strb_d  = S_AXIS_TSTRB;
               h_user_d  = S_AXIS_TUSER;
               h_last_d  = S_AXIS_TLAST;
               if (eligible && !csum_ok) bad_cnt_d = bad_cnt_q + 32'd1;
               if (eligible && csum_ok && !ttl_gt1) ttl_cnt_d = ttl_cnt_q + 32'd1;
               state_d = S_AXIS_TLAST ? DRAIN : BODY;
            end
         end
         BODY: begin
            if (accept) begin
               o_data_d  = h_data_q;
               o_strb_d  = h_strb_q;
               o_user_d  = h_user_q;
               o_last_d  = h_last_q;
               o_valid_d = 1'b1;
               h_data_d  = S_AXIS_TDATA;
               h_strb_d  = S_AXIS_TSTRB;
               h_user_d  = S_AXIS_TUSER;
               h_last_d  = S_AXIS_TLAST;
               if (S_AXIS_TLAST) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (slot_free) begin
               o_data_d  = h_data_q;
               o_strb_d  = h_strb_q;
               o_user_d  = h_user_q;
               o_last_d  = 1'b1;
               o_valid_d = 1'b1;
               h_last_d  = 1'b0;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge AXI_ACLK) begin
      if (reset) begin
         state_q   <= IDLE;
         h_data_q  <= '0;
         h_strb_q  <= '0;
         h_user_q  <= '0;
         h_last_q  <= 1'b0;
         o_data_q  <= '0;
         o_strb_q  <= '0;
         o_user_q  <= '0;
         o_last_q  <= 1'b0;
         o_valid_q <= 1'b0;
         bad_cnt_q <= '0;
         ttl_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         h_data_q  <= h_data_d;
         h_strb_q  <= h_strb_d;
         h_user_q  <= h_user_d;
         h_last_q  <= h_last_d;
         o_data_q  <= o_data_d;
         o_strb_q  <= o_strb_d;
         o_user_q  <= o_user_d;
         o_last_q  <= o_last_d;
         o_valid_q <= o_valid_d;
         bad_cnt_q <= bad_cnt_d;
         ttl_cnt_q <= ttl_cnt_d;
      end
   end

   assign S_AXIS_TREADY      = s_ready;
   assign M_AXIS_TDATA       = o_data_q;
   assign M_AXIS_TSTRB       = o_strb_q;
   assign M_AXIS_TUSER       = o_user_q;
   assign M_AXIS_TVALID      = o_valid_q;
   assign M_AXIS_TLAST       = o_last_q;
   assign bad_checksum_count = bad_cnt_q;
   assign ttl_expired_count  = ttl_cnt_q;

endmodule

// File: tb/tb_ip_ttl_checksum_update.sv
// Bench for ip_ttl_checksum_update: directed header vectors, a mixed random-backpressure run
// against a reference model, and a mid-packet reset.
module tb_ip_ttl_checksum_update;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset;
   logic [255:0] s_tdata;
   logic [31:0]  s_tstrb;
   logic [127:0] s_tuser;
   logic         s_tvalid, s_tlast, s_tready;
   logic [255:0] m_tdata;
   logic [31:0]  m_tstrb;
   logic [127:0] m_tuser;
   logic         m_tvalid, m_tlast, m_tready;
   logic [31:0]  bad_cnt, ttl_cnt;

   ip_ttl_checksum_update dut (
      .AXI_ACLK(clk), .reset(reset),
      .S_AXIS_TDATA(s_tdata), .S_AXIS_TSTRB(s_tstrb), .S_AXIS_TUSER(s_tuser),
      .S_AXIS_TVALID(s_tvalid), .S_AXIS_TLAST(s_tlast), .S_AXIS_TREADY(s_tready),
      .M_AXIS_TDATA(m_tdata), .M_AXIS_TSTRB(m_tstrb), .M_AXIS_TUSER(m_tuser),
      .M_AXIS_TVALID(m_tvalid), .M_AXIS_TLAST(m_tlast), .M_AXIS_TREADY(m_tready),
      .bad_checksum_count(bad_cnt), .ttl_expired_count(ttl_cnt)
   );

   typedef struct {
      logic [255:0] d;
      logic [31:0]  s;
      logic [127:0] u;
      logic         l;
   } beat_t;

   localparam logic [127:0] UBASE  = 128'h0123_4567_89ab_cdef_0000_0000_fedc_ba98;
   localparam logic [127:0] UOTHER = 128'hffff_0000_1111_2222_3333_0007_4444_5555;

   beat_t       pkt[$];
   beat_t       exp_q[$];
   beat_t       got_q[$];
   int          checks = 0;
   int          failures = 0;
   int          rdy_mode = 0;
   bit          use_model = 1'b0;
   logic [31:0] exp_bad = 32'd0;
   logic [31:0] exp_ttl = 32'd0;
   logic [255:0] e0;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] oc_add(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[15:0] + {15'd0, s[16]};
   endfunction

   function automatic logic [15:0] hdr_sum(input logic [255:0] w0, input logic [15:0] w1hw);
      logic [15:0] acc;
      acc = 16'd0;
      for (int i = 0; i < 9; i++) acc = oc_add(acc, w0[16*i +: 16]);
      return oc_add(acc, w1hw);
   endfunction

   // Reference: expected output beats of the packet in pkt, plus counter bookkeeping.
   task automatic model_push();
      beat_t      b;
      logic       elig, ok;
      logic [7:0] ttl;
      for (int i = 0; i < pkt.size(); i++) begin
         b = pkt[i];
         if (i == 0) begin
            elig = (pkt.size() > 1) && (b.d[159:144] == 16'h0800) && (b.d[143:136] == 8'h45);
            b.u[34:32] = 3'b000;
            if (elig) begin
               ok  = (hdr_sum(b.d, pkt[1].d[255:240]) == 16'hFFFF);
               ttl = b.d[79:72];
               b.u[34:32] = {ok && (ttl <= 8'd1), ok, 1'b1};
               if (!ok) exp_bad++;
               else if (ttl <= 8'd1) exp_ttl++;
               else begin
                  b.d[79:72] = ttl - 8'd1;
                  b.d[63:48] = oc_add(b.d[63:48], 16'h0100);
               end
            end
         end
         exp_q.push_back(b);
      end
   endtask

   task automatic build_dir(input logic [15:0] etype, input logic [7:0] ttl,
                            input logic [15:0] hc, input int len);
      beat_t b;
      pkt.delete();
      for (int i = 0; i < len; i++) begin
         case (i)
            0: begin
               b.d = {96'hdead_beef_cafe_f00d_1234_5678, etype,
                      144'h4500_0073_0000_4000_4011_b861_c0a8_0001_c0a8};
               b.d[79:72] = ttl;
               b.d[63:48] = hc;
               b.u = UBASE;
            end
            1: begin
               b.d = {16'h00c7, {15{16'h1357}}};
               b.u = UOTHER;
            end
            default: begin
               b.d = {8{32'h7a7a_0000 + 32'(i)}};
               b.u = UOTHER;
            end
         endcase
         b.s = 32'hffff_ffff;
         b.l = (i == len - 1);
         pkt.push_back(b);
      end
   endtask

   // kind: 0 good, 1 random checksum, 2 TTL 0/1, 3 ARP, 4 single-beat IPv4, 5 IHL 6
   task automatic build(input int kind, input int len);
      beat_t bs[4];
      pkt.delete();
      for (int i = 0; i < len; i++) begin
         bs[i].d = {$urandom(), $urandom(), $urandom(), $urandom(),
                    $urandom(), $urandom(), $urandom(), $urandom()};
         bs[i].s = $urandom();
         bs[i].u = {$urandom(), $urandom(), $urandom(), $urandom()};
         bs[i].l = (i == len - 1);
      end
      if (kind == 3) bs[0].d[159:144] = 16'h0806;
      else begin
         bs[0].d[159:136] = {16'h0800, (kind == 5) ? 8'h46 : 8'h45};
         bs[0].d[79:72] = (kind == 2) ? 8'($urandom_range(0, 1)) : 8'($urandom_range(2, 255));
         if (len > 1 && kind != 1) begin
            bs[0].d[63:48] = 16'h0000;
            bs[0].d[63:48] = ~hdr_sum(bs[0].d, bs[1].d[255:240]);
         end
      end
      for (int i = 0; i < len; i++) pkt.push_back(bs[i]);
   endtask

   task automatic send_pkt();
      int n;
      bit acc;
      for (int i = 0; i < pkt.size(); i++) begin
         @(negedge clk);
         s_tvalid = 1'b1;
         s_tdata  = pkt[i].d;
         s_tstrb  = pkt[i].s;
         s_tuser  = pkt[i].u;
         s_tlast  = pkt[i].l;
         n = 0;
         forever begin
            #1 acc = s_tready;
            @(posedge clk);
            if (acc) break;
            n++;
            if (n > 500) begin
               chk("input_timeout", 256'(n), 256'(0));
               s_tvalid = 1'b0;
               return;
            end
            @(negedge clk);
         end
      end
   endtask

   task automatic wait_got(input int n);
      int k;
      k = 0;
      @(negedge clk);
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      #3;
      while (got_q.size() < n && k < 1000) begin
         @(negedge clk);
         #3;
         k++;
      end
      chk("beat_count", 256'(got_q.size()), 256'(n));
   endtask

   task automatic wait_model();
      int k;
      k = 0;
      @(negedge clk);
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      #3;
      while (exp_q.size() > 0 && k < 5000) begin
         @(negedge clk);
         #3;
         k++;
      end
      chk("model_drain", 256'(exp_q.size()), 256'(0));
      repeat (3) @(negedge clk);
   endtask

   initial begin
      m_tready = 1'b1;
      forever begin
         @(negedge clk);
         case (rdy_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = 1'($urandom_range(0, 1));
            default: m_tready = 1'b0;
         endcase
      end
   end

   initial begin : mon
      beat_t prev, b, e;
      bit stall_prev;
      stall_prev = 1'b0;
      forever begin
         @(negedge clk);
         #2;
         b = '{m_tdata, m_tstrb, m_tuser, m_tlast};
         if (reset) stall_prev = 1'b0;
         else begin
            if (stall_prev) begin
               chk("stall_valid", 256'(m_tvalid), 256'(1'b1));
               chk("stall_data", m_tdata, prev.d);
               chk("stall_user", 256'(m_tuser), 256'(prev.u));
               chk("stall_last", 256'(m_tlast), 256'(prev.l));
            end
            if (m_tvalid && m_tready) begin
               got_q.push_back(b);
               if (use_model) begin
                  if (exp_q.size() == 0) chk("extra_beat", 256'(exp_q.size()), 256'(1));
                  else begin
                     e = exp_q.pop_front();
                     chk("mdl_data", m_tdata, e.d);
                     chk("mdl_user", 256'(m_tuser), 256'(e.u));
                     chk("mdl_strb", 256'(m_tstrb), 256'(e.s));
                     chk("mdl_last", 256'(m_tlast), 256'(e.l));
                  end
               end
            end
            stall_prev = m_tvalid && !m_tready;
         end
         prev = b;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; s_tstrb = '0; s_tuser = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #2;
      chk("rst_m_valid", 256'(m_tvalid), 256'(0));
      chk("rst_m_data", m_tdata, 256'(0));
      chk("rst_bad_cnt", 256'(bad_cnt), 256'(0));
      chk("rst_ttl_cnt", 256'(ttl_cnt), 256'(0));
      chk("rst_s_ready", 256'(s_tready), 256'(1));

      // good header: TTL 0x40 -> 0x3F, checksum 0xB861 -> 0xB961
      build_dir(16'h0800, 8'h40, 16'hb861, 3);
      got_q.delete();
      send_pkt();
      wait_got(3);
      e0 = pkt[0].d;
      e0[79:72] = 8'h3f;
      e0[63:48] = 16'hb961;
      chk("t1_w0_data", got_q[0].d, e0);
      chk("t1_w0_flags", 256'(got_q[0].u[34:32]), 256'(3'b011));
      chk("t1_w0_user", 256'(got_q[0].u), 256'(UBASE | (128'd3 << 32)));
      chk("t1_w1_data", got_q[1].d, pkt[1].d);
      chk("t1_w1_user", 256'(got_q[1].u), 256'(UOTHER));
      chk("t1_w2_data", got_q[2].d, pkt[2].d);
      chk("t1_lasts", 256'({got_q[2].l, got_q[1].l, got_q[0].l}), 256'(3'b100));
      chk("t1_bad_cnt", 256'(bad_cnt), 256'(0));
      chk("t1_ttl_cnt", 256'(ttl_cnt), 256'(0));

      build_dir(16'h0800, 8'h40, 16'hb862, 3);
      got_q.delete();
      send_pkt();
      wait_got(3);
      chk("t2_w0_data", got_q[0].d, pkt[0].d);
      chk("t2_w0_flags", 256'(got_q[0].u[34:32]), 256'(3'b001));
      chk("t2_bad_cnt", 256'(bad_cnt), 256'(1));
      chk("t2_ttl_cnt", 256'(ttl_cnt), 256'(0));

      build_dir(16'h0800, 8'h01, 16'hf761, 3);
      got_q.delete();
      send_pkt();
      wait_got(3);
      chk("t3_w0_data", got_q[0].d, pkt[0].d);
      chk("t3_w0_flags", 256'(got_q[0].u[34:32]), 256'(3'b111));
      chk("t3_bad_cnt", 256'(bad_cnt), 256'(1));
      chk("t3_ttl_cnt", 256'(ttl_cnt), 256'(1));

      build_dir(16'h0806, 8'h40, 16'hb861, 2);
      got_q.delete();
      send_pkt();
      wait_got(2);
      chk("t4_arp_w0", got_q[0].d, pkt[0].d);
      chk("t4_arp_u0", 256'(got_q[0].u), 256'(UBASE));
      chk("t4_arp_w1", got_q[1].d, pkt[1].d);
      chk("t4_arp_u1", 256'(got_q[1].u), 256'(UOTHER));

      build_dir(16'h0800, 8'h40, 16'hb861, 1);
      got_q.delete();
      @(negedge clk);
      s_tvalid = 1'b1; s_tdata = pkt[0].d; s_tstrb = pkt[0].s; s_tuser = pkt[0].u; s_tlast = 1'b1;
      #1 chk("t4_single_ready", 256'(s_tready), 256'(1));
      @(posedge clk);
      @(negedge clk);
      s_tvalid = 1'b0;
      s_tlast = 1'b0;
      #2;
      chk("t4_single_lat", 256'(m_tvalid), 256'(1));
      chk("t4_single_data", m_tdata, pkt[0].d);
      chk("t4_single_user", 256'(m_tuser), 256'(UBASE));
      chk("t4_single_last", 256'(m_tlast), 256'(1));
      repeat (3) @(negedge clk);
      chk("t4_bad_cnt", 256'(bad_cnt), 256'(1));
      chk("t4_ttl_cnt", 256'(ttl_cnt), 256'(1));

      exp_bad = 32'd1;
      exp_ttl = 32'd1;
      exp_q.delete();
      use_model = 1'b1;
      rdy_mode = 1;
      for (int p = 0; p < 100; p++) begin
         int kind, len;
         kind = int'($urandom_range(0, 5));
         len = (kind == 4) ? 1 : (kind == 3) ? int'($urandom_range(1, 4)) : int'($urandom_range(2, 4));
         build(kind, len);
         model_push();
         send_pkt();
      end
      rdy_mode = 0;
      wait_model();
      chk("rnd_bad_cnt", 256'(bad_cnt), 256'(exp_bad));
      chk("rnd_ttl_cnt", 256'(ttl_cnt), 256'(exp_ttl));

      // reset while in BODY with the output stalled
      use_model = 1'b0;
      rdy_mode = 2;
      build_dir(16'h0800, 8'h40, 16'hb861, 3);
      @(negedge clk);
      s_tvalid = 1'b1; s_tdata = pkt[0].d; s_tstrb = pkt[0].s; s_tuser = pkt[0].u; s_tlast = 1'b0;
      @(posedge clk);
      @(negedge clk);
      s_tdata = pkt[1].d; s_tuser = pkt[1].u;
      @(posedge clk);
      @(negedge clk);
      s_tdata = pkt[2].d; s_tuser = pkt[2].u; s_tlast = 1'b1;
      #2;
      chk("rs_pre_valid", 256'(m_tvalid), 256'(1));
      chk("rs_pre_ready", 256'(s_tready), 256'(0));
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      s_tvalid = 1'b0;
      s_tlast = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      rdy_mode = 0;
      #2;
      chk("rs_m_valid", 256'(m_tvalid), 256'(0));
      chk("rs_m_data", m_tdata, 256'(0));
      chk("rs_m_user", 256'(m_tuser), 256'(0));
      chk("rs_bad_cnt", 256'(bad_cnt), 256'(0));
      chk("rs_ttl_cnt", 256'(ttl_cnt), 256'(0));
      chk("rs_s_ready", 256'(s_tready), 256'(1));

      exp_bad = 32'd0;
      exp_ttl = 32'd0;
      exp_q.delete();
      got_q.delete();
      use_model = 1'b1;
      model_push();
      send_pkt();
      wait_model();
      chk("post_ttl", 256'(got_q[0].d[79:72]), 256'(8'h3f));
      chk("post_csum", 256'(got_q[0].d[63:48]), 256'(16'hb961));
      chk("post_bad_cnt", 256'(bad_cnt), 256'(0));
      chk("post_ttl_cnt", 256'(ttl_cnt), 256'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
